// File: rtl/demux_1to32_collect.sv
// Serial-bit collector: writes data_i into out_o[sel_i] until every position
// has been written, then holds the assembled word under a valid/ready handoff.
module demux_1to32_collect #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             data_i,
  input  logic [SEL_W-1:0] sel_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             clear_i,
  output logic [WIDTH-1:0] out_o,
  output logic [WIDTH-1:0] mask_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             dup_o
);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] out_d, mask_d, sel_oh;
  logic             ready_d, dup_d, wr, hit;

  for (genvar i = 0; i < WIDTH; i++) begin : g_dec
    assign sel_oh[i] = (sel_i == SEL_W'(i));
  end

  assign wr      = valid_i & ready_o;
  assign hit     = |(mask_o & sel_oh);
  assign valid_o = (state_q == HOLD);

  always_comb begin
    state_d = state_q;
    out_d   = out_o;
    mask_d  = mask_o;
    dup_d   = 1'b0;
    if (clear_i) begin
      // Discard wins over any concurrent write, handoff or duplicate report.
      state_d = COLLECT;
      out_d   = '0;
      mask_d  = '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (wr) begin
            out_d  = (out_o & ~sel_oh) | (data_i ? sel_oh : '0);
            mask_d = mask_o | sel_oh;
            dup_d  = hit;
            // Only a fresh position can finish the word.
            if (!hit && (&(mask_o | sel_oh))) state_d = HOLD;
          end
        end
        HOLD: begin
          if (ready_i) begin
            state_d = COLLECT;
            out_d   = '0;
            mask_d  = '0;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
    ready_d = (state_d == COLLECT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= COLLECT;
      out_o   <= '0;
      mask_o  <= '0;
      dup_o   <= 1'b0;
      ready_o <= 1'b0;
    end else begin
      state_q <= state_d;
      out_o   <= out_d;
      mask_o  <= mask_d;
      dup_o   <= dup_d;
      ready_o <= ready_d;
    end
  end

endmodule

// File: tb/tb_demux_1to32_collect.sv
// Bench for demux_1to32_collect: directed scenarios against constants plus a
// randomized run against an array-based reference model.
module tb_demux_1to32_collect;

  logic        clk_i = 1'b0;
  logic        rst_i, data_i, valid_i, clear_i, ready_i;
  logic [4:0]  sel_i;
  logic        ready_o, valid_o, dup_o;
  logic [31:0] out_o, mask_o;

  int n_cmp = 0;
  int n_bad = 0;

  demux_1to32_collect dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .sel_i(sel_i),
    .valid_i(valid_i), .ready_o(ready_o), .clear_i(clear_i), .out_o(out_o),
    .mask_o(mask_o), .valid_o(valid_o), .ready_i(ready_i), .dup_o(dup_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: per-position value and written flag, plus a count.
  bit m_bit[32];
  bit m_wr[32];
  int m_cnt;
  bit m_full, m_ready, m_dup;

  task automatic m_wipe();
    for (int i = 0; i < 32; i++) begin m_bit[i] = 0; m_wr[i] = 0; end
    m_cnt = 0; m_full = 0;
  endtask

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_wipe(); m_ready = 0; m_dup = 0;
    end else begin
      m_dup = 0;
      if (clear_i) m_wipe();
      else if (m_full) begin
        if (ready_i) m_wipe();
      end else if (valid_i && m_ready) begin
        if (m_wr[sel_i]) m_dup = 1;
        else begin m_wr[sel_i] = 1; m_cnt++; end
        m_bit[sel_i] = data_i;
        if (m_cnt == 32) m_full = 1;
      end
      m_ready = !m_full;
    end
  end

  function automatic logic [31:0] m_word();
    logic [31:0] w = '0;
    for (int i = 0; i < 32; i++) w[i] = m_bit[i];
    return w;
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] w = '0;
    for (int i = 0; i < 32; i++) w[i] = m_wr[i];
    return w;
  endfunction

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic idle();
    valid_i = 0; data_i = 0; sel_i = '0; clear_i = 0;
  endtask

  task automatic fill_word(input logic [31:0] w);
    for (int i = 0; i < 32; i++) begin
      valid_i = 1; sel_i = 5'(i); data_i = w[i];
      tick();
    end
    idle();
  endtask

  task automatic test_reset();
    rst_i = 1; ready_i = 0; idle();
    #2;
    n_cmp++;
    if (out_o !== 0 || mask_o !== 0 || valid_o !== 0 || dup_o !== 0 || ready_o !== 0) begin
      n_bad++;
      $display("FAIL reset_async: out=%h mask=%h valid=%b dup=%b ready=%b, want all 0",
               out_o, mask_o, valid_o, dup_o, ready_o);
    end
    tick(); tick();
    rst_i = 0;
    tick();
    n_cmp++;
    if (ready_o !== 1) begin n_bad++; $display("FAIL reset_ready: ready=%b want 1", ready_o); end
  endtask

  task automatic test_seq_write();
    logic [31:0] pat = 32'hA99999CC;
    ready_i = 1;
    for (int i = 0; i < 32; i++) begin
      valid_i = 1; sel_i = 5'(i); data_i = pat[i];
      tick();
      if (i == 30) begin
        n_cmp++;
        if (valid_o !== 0) begin n_bad++; $display("FAIL seq_early_valid: valid=%b want 0", valid_o); end
      end
    end
    idle();
    n_cmp++;
    if (valid_o !== 1 || out_o !== pat || mask_o !== 32'hFFFFFFFF || ready_o !== 0) begin
      n_bad++;
      $display("FAIL seq_done: valid=%b out=%h mask=%h ready=%b, want 1 %h ffffffff 0",
               valid_o, out_o, mask_o, ready_o, pat);
    end
    tick();
    n_cmp++;
    if (ready_o !== 1 || mask_o !== 0 || valid_o !== 0 || out_o !== 0) begin
      n_bad++;
      $display("FAIL seq_handoff: ready=%b mask=%h valid=%b out=%h, want 1 0 0 0",
               ready_o, mask_o, valid_o, out_o);
    end
    ready_i = 0;
  endtask

  task automatic test_hold();
    ready_i = 0;
    for (int i = 31; i >= 0; i--) begin
      valid_i = 1; sel_i = 5'(i); data_i = 1;
      tick();
    end
    for (int c = 0; c < 5; c++) begin
      valid_i = 1; sel_i = 5'($urandom_range(31)); data_i = 1'($urandom);
      tick();
      n_cmp++;
      if (valid_o !== 1 || out_o !== 32'hFFFFFFFF || ready_o !== 0 || dup_o !== 0
          || mask_o !== 32'hFFFFFFFF) begin
        n_bad++;
        $display("FAIL hold_frozen: valid=%b out=%h ready=%b dup=%b mask=%h, want 1 ffffffff 0 0 ffffffff",
                 valid_o, out_o, ready_o, dup_o, mask_o);
      end
    end
    idle(); ready_i = 1;
    tick();
    ready_i = 0;
    n_cmp++;
    if (out_o !== 0 || valid_o !== 0) begin
      n_bad++; $display("FAIL hold_release: out=%h valid=%b want 0 0", out_o, valid_o);
    end
  endtask

  task automatic test_dup();
    valid_i = 1; sel_i = 5'b10100; data_i = 0;
    tick();
    n_cmp++;
    if (dup_o !== 0) begin n_bad++; $display("FAIL dup_first: dup=%b want 0", dup_o); end
    data_i = 1;
    tick();
    idle();
    n_cmp++;
    if (dup_o !== 1 || out_o !== 32'h00100000 || mask_o !== 32'h00100000 || valid_o !== 0) begin
      n_bad++;
      $display("FAIL dup_second: dup=%b out=%h mask=%h valid=%b, want 1 00100000 00100000 0",
               dup_o, out_o, mask_o, valid_o);
    end
    tick();
    n_cmp++;
    if (dup_o !== 0) begin n_bad++; $display("FAIL dup_pulse: dup=%b want 0", dup_o); end
    clear_i = 1; tick(); clear_i = 0;
  endtask

  task automatic test_clear();
    for (int i = 0; i < 16; i++) begin
      valid_i = 1; sel_i = 5'(i); data_i = 1;
      tick();
    end
    n_cmp++;
    if (mask_o !== 32'h0000FFFF) begin n_bad++; $display("FAIL clear_pre: mask=%h want 0000ffff", mask_o); end
    clear_i = 1; valid_i = 1; sel_i = 5'd16; data_i = 1;
    tick();
    idle();
    n_cmp++;
    if (mask_o !== 0 || out_o !== 0 || ready_o !== 1) begin
      n_bad++;
      $display("FAIL clear_wipe: mask=%h out=%h ready=%b want 0 0 1", mask_o, out_o, ready_o);
    end
  endtask

  task automatic test_rst_hold();
    logic [31:0] w = $urandom;
    int perm[32];
    ready_i = 0;
    fill_word(w);
    n_cmp++;
    if (valid_o !== 1 || out_o !== w) begin
      n_bad++; $display("FAIL rsthold_pre: valid=%b out=%h want 1 %h", valid_o, out_o, w);
    end
    #2 rst_i = 1;
    #1;
    n_cmp++;
    if (out_o !== 0 || mask_o !== 0 || valid_o !== 0 || ready_o !== 0) begin
      n_bad++;
      $display("FAIL rsthold_async: out=%h mask=%h valid=%b ready=%b want 0", out_o, mask_o, valid_o, ready_o);
    end
    tick(); rst_i = 0; tick();
    for (int i = 0; i < 32; i++) perm[i] = i;
    for (int i = 31; i > 0; i--) begin
      int j = $urandom_range(i);
      int t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    w = $urandom;
    for (int i = 0; i < 32; i++) begin
      valid_i = 1; sel_i = 5'(perm[i]); data_i = w[perm[i]];
      tick();
    end
    idle();
    n_cmp++;
    if (valid_o !== 1 || out_o !== w) begin
      n_bad++; $display("FAIL rsthold_fresh: valid=%b out=%h want 1 %h", valid_o, out_o, w);
    end
    ready_i = 1; tick(); ready_i = 0;
  endtask

  task automatic test_hold_write();
    ready_i = 0;
    fill_word(32'h12345678);
    ready_i = 1; valid_i = 1; sel_i = 5'd3; data_i = 1;
    tick();
    n_cmp++;
    if (mask_o !== 0 || out_o !== 0 || valid_o !== 0 || ready_o !== 1) begin
      n_bad++;
      $display("FAIL holdwr_handoff: mask=%h out=%h valid=%b ready=%b want 0 0 0 1",
               mask_o, out_o, valid_o, ready_o);
    end
    idle(); ready_i = 0;
    tick();
    n_cmp++;
    if (mask_o !== 0) begin n_bad++; $display("FAIL holdwr_ignored: mask=%h want 0", mask_o); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      valid_i = ($urandom_range(9) < 7);
      sel_i   = 5'($urandom_range(31));
      data_i  = 1'($urandom);
      clear_i = ($urandom_range(99) < 2);
      ready_i = 1'($urandom);
      tick();
      n_cmp++;
      if (out_o !== m_word() || mask_o !== m_mask() || valid_o !== m_full
          || ready_o !== m_ready || dup_o !== m_dup) begin
        n_bad++;
        $display("FAIL random[%0d]: out=%h mask=%h valid=%b ready=%b dup=%b, want %h %h %b %b %b",
                 c, out_o, mask_o, valid_o, ready_o, dup_o,
                 m_word(), m_mask(), m_full, m_ready, m_dup);
      end
    end
    idle(); ready_i = 0;
  endtask

  initial begin
    test_reset();
    test_seq_write();
    test_hold();
    test_dup();
    test_clear();
    test_rst_hold();
    test_hold_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demux_1to32_collect.md
Name: demux_1to32_collect

Overview:
Inverse of the 32-to-1 bit selector. It accepts one serial bit per transfer, together with a 5-bit destination index, and writes that bit into the matching position of a 32-bit word. Once all 32 positions have been written, it presents the assembled word to a downstream consumer under a valid/ready handshake. It sits wherever a bit-selected stream must be turned back into a parallel word.

Parameters:
WIDTH, 32, number of bit positions in the assembled word; must be a power of 2.
SEL_W, 5, width of the index; equals log2(WIDTH).

Ports:
clk_i  input  1  clock; all state changes on the rising edge.
rst_i  input  1  asynchronous, active-high reset.
data_i  input  1  serial bit to be written.
sel_i  input  SEL_W  destination bit position for data_i.
valid_i  input  1  write strobe qualifying data_i and sel_i.
ready_o  output  1  block can accept a write this cycle.
clear_i  input  1  synchronous discard of the current word.
out_o  output  WIDTH  assembled word; shows partial content while collecting.
mask_o  output  WIDTH  bit i = 1 when position i has been written since the last handoff or clear.
valid_o  output  1  word complete, held until accepted.
ready_i  input  1  downstream accepts the word.
dup_o  output  1  one-cycle pulse reporting a write to an already-written position.

Behaviour:
- Reset: one clock, clk_i; rst_i is asynchronous and active-high.
  - While rst_i is high, with no clock edge required: out_o=0, mask_o=0, valid_o=0, dup_o=0, ready_o=0, state=COLLECT.
  - ready_o rises in the first cycle after rst_i deasserts.
- State COLLECT:
  - ready_o=1, valid_o=0.
  - A write occurs when valid_i && ready_o at the clock edge: out_o[sel_i] <= data_i and mask_o[sel_i] <= 1.
  - Unwritten positions of out_o read 0.
  - When a write makes mask_o all ones, the state is HOLD after that same edge. valid_o is therefore high in the cycle immediately following the last write (latency 1 clock).
- State HOLD:
  - ready_o=0, valid_o=1; out_o and mask_o are frozen.
  - valid_i is ignored; it sets neither dup_o nor any mask bit.
  - On ready_i high at an edge: out_o <= 0, mask_o <= 0, valid_o <= 0, state returns to COLLECT.
  - ready_o is therefore 1 in the cycle after the handoff.
- Duplicate write (COLLECT, mask_o[sel_i] already 1):
  - The bit is overwritten with the new data_i and mask_o is unchanged.
  - dup_o = 1 for exactly the next cycle.
  - A duplicate write never completes a word.
- clear_i (any state, synchronous):
  - Next state is COLLECT with out_o=0, mask_o=0, valid_o=0, dup_o=0.
  - It overrides a simultaneous write, a simultaneous handoff and a duplicate flag; the write is discarded.
- Index range: sel_i is always in range because WIDTH = 2^SEL_W; no out-of-range handling exists.
- Completion: writes may arrive in any order and with any gaps. Completion depends only on mask_o reaching all ones.
- Back-to-back: one write is accepted per cycle in COLLECT, so the minimum time to assemble a word is 32 cycles.

Test Plan:
1. Reset, then write sel_i=0..31 in consecutive cycles with bits of 32'hA99999CC (bit i to sel i), ready_i=1 → valid_o high exactly 1 cycle after the 32nd write with out_o=32'hA99999CC, then ready_o=1 and mask_o=0 on the next cycle.
2. Write sel_i=31 down to 0 all with data 1, hold ready_i=0 for 5 cycles while driving valid_i=1 → valid_o stays 1, out_o=32'hFFFFFFFF, ready_o=0, dup_o=0 throughout; raise ready_i → next cycle out_o=0, valid_o=0.
3. Write sel_i=5'b10100 with data 0, then again with data 1 → dup_o=1 for one cycle, out_o[20]=1, mask_o=32'h00100000, valid_o stays 0.
4. After 16 writes (sel 0..15, data 1), assert clear_i together with valid_i (sel=16, data=1) → next cycle mask_o=0, out_o=0, bit 16 not written, ready_o=1.
5. Complete a word and assert rst_i mid-HOLD between clock edges → out_o, mask_o and valid_o drop to 0 immediately; after release, a fresh 32-write word completes normally.
6. In HOLD, assert ready_i and valid_i (sel=3, data=1) in the same cycle → handoff occurs, the write is ignored, and mask_o=0 on the next cycle.
